ibex_hpm_counter_bank: RTL and testbench

- Parametrised bank of RISC-V hardware performance monitor counters: mhpmcounter3..N+2, their high halves, and the mhpmevent3..N+2 selectors.
- Replaces fixed-width, fixed-count HPM logic inside the CSR file with a configurable counter count, counter width and event-vector width.
- Adds per-counter overflow pulses and debug stop-count support.
- Sits beside ibex_cs_registers. That block owns mcountinhibit and dcsr, performs CSR op resolution (set/clear/write) and muxes csr_rdata_o into its read path.

---
 rtl/ibex_hpm_counter_bank.sv | 129 ++++++++++++
 tb/tb_ibex_hpm_counter_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_hpm_counter_bank.sv
// Bank of RISC-V hardware performance counters: mhpmcounter/mhpmcounterh/mhpmevent
// for indices 3..NumCounters+2, with per-counter wrap pulses and debug stop-count.
module ibex_hpm_counter_bank #(
    parameter int unsigned NumCounters  = 10,
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumEvents-1:0]   event_i,
    input  logic [NumCounters-1:0] inhibit_i,
    input  logic                   stopcount_i,
    input  logic [11:0]            csr_addr_i,
    input  logic                   csr_we_i,
    input  logic [31:0]            csr_wdata_i,
    output logic                   csr_hit_o,
    output logic [31:0]            csr_rdata_o,
    output logic [NumCounters-1:0] overflow_o
);

    localparam int unsigned LoWidth   = (CounterWidth > 32) ? 32 : CounterWidth;
    localparam logic [6:0]  EventPage = 7'h19;  // 12'h320 >> 5
    localparam logic [6:0]  LoPage    = 7'h58;  // 12'hB00 >> 5
    localparam logic [6:0]  HiPage    = 7'h5C;  // 12'hB80 >> 5

    logic [4:0] csr_idx;
    logic       is_event;
    logic       is_lo;
    logic       is_hi;

    logic [NumCounters-1:0][31:0] event_rd;
    logic [NumCounters-1:0][31:0] lo_rd;
    logic [NumCounters-1:0][31:0] hi_rd;
    logic [NumCounters-1:0]       ovf_d;

    // Address decode: three 32-entry pages, indices 0..2 belong to other CSRs
    assign csr_idx   = csr_addr_i[4:0];
    assign is_event  = (csr_addr_i[11:5] == EventPage);
    assign is_lo     = (csr_addr_i[11:5] == LoPage);
    assign is_hi     = (csr_addr_i[11:5] == HiPage);
    assign csr_hit_o = (is_event | is_lo | is_hi) & (csr_idx >= 5'd3);

    for (genvar g = 0; g < NumCounters; g++) begin : g_counter
        localparam logic [4:0] Idx = 5'(g + 3);

        logic                    sel;
        logic                    wr_event;
        logic                    wr_lo;
        logic                    wr_hi;
        logic                    inc;
        logic [NumEvents-1:0]    event_sel_q;
        logic [CounterWidth-1:0] cnt_q;
        logic [CounterWidth-1:0] cnt_d;
        logic [CounterWidth-1:0] lo_merge;
        logic [CounterWidth-1:0] hi_merge;

        assign sel      = csr_we_i & (csr_idx == Idx);
        assign wr_event = sel & is_event;
        assign wr_lo    = sel & is_lo;
        assign inc      = (|(event_sel_q & event_i)) & ~inhibit_i[g] & ~stopcount_i;

        // Half-word merges; narrow counters have no writable high half
        if (CounterWidth > 32) begin : g_wide
            assign lo_merge = {cnt_q[CounterWidth-1:32], csr_wdata_i};
            assign hi_merge = {csr_wdata_i[CounterWidth-33:0], cnt_q[31:0]};
            assign wr_hi    = sel & is_hi;
            assign hi_rd[g] = 32'(cnt_q[CounterWidth-1:32]);
        end else begin : g_narrow
            assign lo_merge = csr_wdata_i[CounterWidth-1:0];
            assign hi_merge = cnt_q;
            assign wr_hi    = 1'b0;
            assign hi_rd[g] = '0;
        end

        // A CSR write beats the increment and suppresses that cycle's wrap pulse
        always_comb begin
            cnt_d = cnt_q;
            if (wr_lo) begin
                cnt_d = lo_merge;
            end else if (wr_hi) begin
                cnt_d = hi_merge;
            end else if (inc) begin
                cnt_d = cnt_q + CounterWidth'(1);
            end
        end

        assign ovf_d[g] = inc & ~wr_lo & ~wr_hi & (&cnt_q);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q       <= '0;
                event_sel_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (wr_event) begin
                    event_sel_q <= csr_wdata_i[NumEvents-1:0];
                end
            end
        end

        assign event_rd[g] = 32'(event_sel_q);
        assign lo_rd[g]    = 32'(cnt_q[LoWidth-1:0]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= '0;
        end else begin
            overflow_o <= ovf_d;
        end
    end

    // Read mux; unimplemented indices and misses return zero
    always_comb begin
        csr_rdata_o = '0;
        for (int unsigned i = 0; i < NumCounters; i++) begin
            if (csr_hit_o && (csr_idx == 5'(i + 3))) begin
                if (is_event) begin
                    csr_rdata_o = event_rd[i];
                end else if (is_lo) begin
                    csr_rdata_o = lo_rd[i];
                end else begin
                    csr_rdata_o = hi_rd[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Bench for ibex_hpm_counter_bank: directed scenarios plus randomized traffic
// checked against a cycle-level arithmetic model of the counter bank.
module tb_ibex_hpm_counter_bank;

    localparam int unsigned NC = 10;
    localparam int unsigned CW = 40;
    localparam int unsigned NE = 16;
    localparam longint unsigned CMASK  = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                    : ((64'd1 << CW) - 64'd1);
    localparam int unsigned     EVMASK = (NE == 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << NE) - 32'd1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NE-1:0] events = '0;
    logic [NC-1:0] inhibit = '0;
    logic          stopcount = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic          csr_we = 1'b0;
    logic [31:0]   csr_wdata = '0;
    logic          csr_hit;
    logic [31:0]   csr_rdata;
    logic [NC-1:0] overflow;

    int checks = 0;
    int failures = 0;

    longint unsigned m_cnt [NC];
    int unsigned     m_ev  [NC];
    bit              m_ovf [NC];

    always #5 clk = ~clk;

    ibex_hpm_counter_bank #(
        .NumCounters (NC),
        .CounterWidth(CW),
        .NumEvents   (NE)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .event_i    (events),
        .inhibit_i  (inhibit),
        .stopcount_i(stopcount),
        .csr_addr_i (csr_addr),
        .csr_we_i   (csr_we),
        .csr_wdata_i(csr_wdata),
        .csr_hit_o  (csr_hit),
        .csr_rdata_o(csr_rdata),
        .overflow_o (overflow)
    );

    // Reference model: counters as plain integers, wrap by modulo arithmetic
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NC); i++) begin
                m_cnt[i] = 0;
                m_ev[i]  = 0;
                m_ovf[i] = 0;
            end
        end else begin
            for (int i = 0; i < int'(NC); i++) begin
                bit inc;
                inc = ((m_ev[i] & 32'(events)) != 0) && !inhibit[i] && !stopcount;
                m_ovf[i] = 0;
                if (csr_we && csr_addr == 12'(32'hB00 + i + 3)) begin
                    m_cnt[i] = ((m_cnt[i] & ~64'hFFFF_FFFF) | 64'(csr_wdata)) & CMASK;
                end else if (csr_we && csr_addr == 12'(32'hB80 + i + 3) && CW > 32) begin
                    m_cnt[i] = ((64'(csr_wdata) << 32) | (m_cnt[i] & 64'hFFFF_FFFF)) & CMASK;
                end else if (inc) begin
                    m_cnt[i] = (m_cnt[i] + 1) & CMASK;
                    m_ovf[i] = (m_cnt[i] == 0);
                end
                if (csr_we && csr_addr == 12'(32'h320 + i + 3)) begin
                    m_ev[i] = csr_wdata & EVMASK;
                end
            end
        end
    end

    function automatic logic exp_hit(input logic [11:0] a);
        int unsigned v;
        v = 32'(a);
        return (v >= 32'h323 && v <= 32'h33F) || (v >= 32'hB03 && v <= 32'hB1F) ||
               (v >= 32'hB83 && v <= 32'hB9F);
    endfunction

    function automatic logic [31:0] exp_read(input logic [11:0] a);
        int unsigned v;
        v = 32'(a);
        if (v >= 32'h323 && v <= 32'h33F && (v - 32'h323) < NC)
            return m_ev[v - 32'h323];
        if (v >= 32'hB03 && v <= 32'hB1F && (v - 32'hB03) < NC)
            return 32'(m_cnt[v - 32'hB03] & 64'hFFFF_FFFF);
        if (v >= 32'hB83 && v <= 32'hB9F && (v - 32'hB83) < NC && CW > 32)
            return 32'(m_cnt[v - 32'hB83] >> 32);
        return 32'h0;
    endfunction

    function automatic logic [NC-1:0] exp_ovf();
        logic [NC-1:0] r;
        for (int i = 0; i < int'(NC); i++) r[i] = m_ovf[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        chk({tag, "_rdata"}, 64'(csr_rdata), 64'(exp_read(csr_addr)));
        chk({tag, "_hit"}, 64'(csr_hit), 64'(exp_hit(csr_addr)));
        chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf()));
    endtask

    task automatic peek(input logic [11:0] a, input string tag);
        csr_addr = a;
        csr_we   = 1'b0;
        #1;
        check_now(tag);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input string tag);
        csr_addr  = a;
        csr_we    = 1'b1;
        csr_wdata = d;
        @(negedge clk);
        check_now(tag);
        csr_we = 1'b0;
    endtask

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] e4;
        int          k;

        // Reset and idle
        repeat (2) @(negedge clk);
        peek(12'hB03, "in_reset");
        chk("in_reset_b03", 64'(csr_rdata), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        peek(12'hB03, "idle_b03");
        chk("idle_b03_zero", 64'(csr_rdata), 64'h0);
        peek(12'hB83, "idle_b83");
        chk("idle_b83_zero", 64'(csr_rdata), 64'h0);
        peek(12'h323, "idle_323");
        chk("idle_323_zero", 64'(csr_rdata), 64'h0);
        @(negedge clk);
        chk("idle_ovf_zero", 64'(overflow), 64'h0);
        peek(12'hB1F, "hit_b1f");
        chk("hit_b1f_one", 64'(csr_hit), 64'h1);
        peek(12'hB20, "hit_b20");
        chk("hit_b20_zero", 64'(csr_hit), 64'h0);
        @(negedge clk);

        // One increment per cycle with two selected events firing
        wr(12'h323, 32'h0000_0005, "evsel3");
        csr_addr = 12'hB03;
        events   = 16'h0005;
        repeat (10) @(negedge clk);
        chk("count_10", 64'(csr_rdata), 64'd10);
        check_now("count_10m");
        events = 16'h0002;
        repeat (3) @(negedge clk);
        chk("unselected_hold", 64'(csr_rdata), 64'd10);
        events = '0;

        // Wrap from all-ones
        wr(12'hB83, 32'h0000_00FF, "wrhi_ff");
        wr(12'hB03, 32'hFFFF_FFFF, "wrlo_ones");
        events = 16'h0001;
        @(negedge clk);
        events = '0;
        chk("wrap_lo_zero", 64'(csr_rdata), 64'h0);
        chk("ovf_pulse", 64'(overflow[0]), 64'h1);
        check_now("wrap");
        @(negedge clk);
        chk("ovf_single", 64'(overflow), 64'h0);
        peek(12'hB83, "wrap_hi");
        chk("wrap_hi_zero", 64'(csr_rdata), 64'h0);
        wr(12'hB83, 32'hFFFF_FFFF, "hi_trunc");
        chk("hi_trunc_ff", 64'(csr_rdata), 64'h0000_00FF);

        // Write/increment collision, inhibit, stopcount
        wr(12'hB03, 32'd5, "set5");
        wr(12'h324, 32'h1, "evsel4");
        events = 16'h0001;
        wr(12'hB03, 32'd100, "collision");
        chk("collision_100", 64'(csr_rdata), 64'd100);
        inhibit[0] = 1'b1;
        @(negedge clk);
        chk("inhibit_hold", 64'(csr_rdata), 64'd100);
        check_now("inhibit");
        inhibit[0] = 1'b0;
        stopcount  = 1'b1;
        csr_addr   = 12'hB04;
        #1;
        e4 = exp_read(12'hB04);
        check_now("stop_c4_pre");
        repeat (3) @(negedge clk);
        chk("stop_hold_c4", 64'(csr_rdata), 64'(e4));
        peek(12'hB03, "stop_c3");
        chk("stop_hold_c3", 64'(csr_rdata), 64'd100);
        stopcount = 1'b0;
        events    = '0;
        @(negedge clk);

        // Unimplemented index and event-selector width
        a = 12'(32'hB00 + NC + 3);
        wr(a, 32'd7, "unimpl");
        chk("unimpl_zero", 64'(csr_rdata), 64'h0);
        chk("unimpl_hit", 64'(csr_hit), 64'h1);
        wr(12'h323, 32'hFFFF_FFFF, "evmask");
        chk("evmask_ffff", 64'(csr_rdata), 64'h0000_FFFF);

        // Asynchronous reset mid-count
        wr(12'hB03, 32'd50, "set50");
        events = 16'h0001;
        @(negedge clk);
        chk("count_51", 64'(csr_rdata), 64'd51);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cnt_zero", 64'(csr_rdata), 64'h0);
        chk("rst_ovf_zero", 64'(overflow), 64'h0);
        csr_addr = 12'h323;
        #1;
        chk("rst_evsel_zero", 64'(csr_rdata), 64'h0);
        check_now("rst");
        @(negedge clk);
        rst_n = 1'b1;
        wr(12'h323, 32'h1, "resel");
        csr_addr = 12'hB03;
        repeat (3) @(negedge clk);
        chk("resume_3", 64'(csr_rdata), 64'd3);
        events = '0;

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            k = int'($urandom_range(0, 9));
            a = 12'($urandom_range(0, 15));
            if (k <= 2)      a = 12'h320 + a;
            else if (k <= 5) a = 12'hB00 + a;
            else if (k <= 8) a = 12'hB80 + a;
            else             a = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: d = 32'h0000_00FF;
            endcase
            csr_addr  = a;
            csr_wdata = d;
            csr_we    = ($urandom_range(0, 3) == 0);
            events    = NE'($urandom) & NE'($urandom);
            inhibit   = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
            stopcount = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            check_now("rand");
        end
        csr_we    = 1'b0;
        events    = '0;
        inhibit   = '0;
        stopcount = 1'b0;

        // Final sweep of every address in the three pages
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 32; i++) begin
                a = (p == 0) ? 12'(32'h320 + i) : (p == 1) ? 12'(32'hB00 + i) : 12'(32'hB80 + i);
                peek(a, "sweep");
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
